// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port of the multicycle core.
// Round-robin grant on contention, fixed-latency access, one-cycle ack per owner.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  input  logic          ld_req_i,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic [DW-1:0] ld_rdata_o,
  output logic          ld_ack_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       owner_ld_q;
  logic       last_ld_q;
  logic       grant_ld;

  // Loader wins when alone, or when both request and the CPU was served last.
  assign grant_ld = ld_req_i && (!cpu_req_i || !last_ld_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_ld_q  <= 1'b0;
      last_ld_q   <= 1'b1;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_ack_o   <= 1'b0;
      ld_ack_o    <= 1'b0;
      cpu_rdata_o <= '0;
      ld_rdata_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      cpu_ack_o <= 1'b0;
      ld_ack_o  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req_i || ld_req_i) begin
            owner_ld_q  <= grant_ld;
            last_ld_q   <= grant_ld;
            mem_we_o    <= grant_ld ? ld_we_i : cpu_we_i;
            mem_addr_o  <= grant_ld ? ld_addr_i : cpu_addr_i;
            mem_wdata_o <= grant_ld ? ld_wdata_i : cpu_wdata_i;
            cnt_q       <= CntInit;
            mem_en_o    <= 1'b1;
            busy_o      <= 1'b1;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            if (!mem_we_o) begin
              if (owner_ld_q) ld_rdata_o  <= mem_rdata_i;
              else            cpu_rdata_o <= mem_rdata_i;
            end
            ld_ack_o  <= owner_ld_q;
            cpu_ack_o <= !owner_ld_q;
            mem_en_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            state_q   <= StAck;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
